gpio_mmio: RTL and testbench

Memory-mapped GPIO peripheral for the single-cycle processor's data bus, replacing the fixed 10-switch/10-LED decode in `top`. Widths and base address are parameters, switch inputs are synchronised and optionally debounced, and LEDs support write/set/clear/toggle. Sticky per-switch change flags drive a maskable interrupt. The block sits beside data memory on `DataAdr`/`WriteData`/`MemWrite` and supplies read data to the processor's read mux.

---
 rtl/gpio_mmio_if.sv | 11 +
 rtl/gpio_mmio.sv | 132 +++++++++++++
 tb/tb_gpio_mmio.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_mmio_if.sv
// gpio_mmio_if: processor data-bus view of the GPIO peripheral.
// The processor drives address, write data and the write strobe; the peripheral returns read data.
interface gpio_mmio_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData);
endinterface

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped switches/LEDs with sticky change flags and a maskable level irq.
// Define GPIO_DEBOUNCE_EN to build per-switch debounce counters of DEBOUNCE_CYCLES stable edges.
module gpio_mmio #(
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned LED_WIDTH       = 10,
  parameter logic [31:0] BASE_ADDR       = 32'hC000_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_mmio_if.slave           bus,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);
  localparam logic [2:0] OFF_SW      = 3'd0;
  localparam logic [2:0] OFF_LED     = 3'd1;
  localparam logic [2:0] OFF_LED_SET = 3'd2;
  localparam logic [2:0] OFF_LED_CLR = 3'd3;
  localparam logic [2:0] OFF_LED_TGL = 3'd4;
  localparam logic [2:0] OFF_EDGE    = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN  = 3'd6;

  logic                 hit;
  logic [2:0]           sel;
  logic                 wr;
  logic [SW_WIDTH-1:0]  wd_sw;
  logic [LED_WIDTH-1:0] wd_led;

  assign hit    = (bus.DataAdr[31:5] == BASE_ADDR[31:5]);
  assign sel    = bus.DataAdr[4:2];
  assign wr     = bus.MemWrite & hit;
  assign wd_sw  = bus.WriteData[SW_WIDTH-1:0];
  assign wd_led = bus.WriteData[LED_WIDTH-1:0];

  logic [SW_WIDTH-1:0] sync1_reg;
  logic [SW_WIDTH-1:0] s_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      s_reg     <= '0;
    end else begin
      sync1_reg <= switches;
      s_reg     <= sync1_reg;
    end
  end

  // deb is the accepted switch state; deb_next is the value it takes on the coming edge.
  logic [SW_WIDTH-1:0] deb;
  logic [SW_WIDTH-1:0] deb_next;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_deb
    logic [CW-1:0] cnt_reg;
    logic          deb_reg;

    assign deb[gi]      = deb_reg;
    assign deb_next[gi] = (s_reg[gi] != deb_reg && cnt_reg == CNT_LAST) ? s_reg[gi] : deb_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
        deb_reg <= 1'b0;
      end else if (s_reg[gi] == deb_reg || cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        deb_reg <= deb_next[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
`else
  // Without debounce the synchroniser output is the accepted state.
  assign deb      = s_reg;
  assign deb_next = sync1_reg;
`endif

  logic [SW_WIDTH-1:0]  edge_reg;
  logic [SW_WIDTH-1:0]  irq_en_reg;
  logic [SW_WIDTH-1:0]  edge_clr;
  logic [LED_WIDTH-1:0] led_reg;

  assign edge_clr = (wr && sel == OFF_EDGE) ? wd_sw : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_reg   <= '0;
      irq_en_reg <= '0;
      led_reg    <= '0;
    end else begin
      // A change on this edge beats a coincident write-1-to-clear.
      edge_reg <= (edge_reg & ~edge_clr) | (deb ^ deb_next);
      if (wr) begin
        case (sel)
          OFF_LED:     led_reg    <= wd_led;
          OFF_LED_SET: led_reg    <= led_reg | wd_led;
          OFF_LED_CLR: led_reg    <= led_reg & ~wd_led;
          OFF_LED_TGL: led_reg    <= led_reg ^ wd_led;
          OFF_IRQ_EN:  irq_en_reg <= wd_sw;
          default: ;
        endcase
      end
    end
  end

  assign leds = led_reg;
  assign irq  = |(edge_reg & irq_en_reg);

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        OFF_SW:     rdata[SW_WIDTH-1:0]  = deb;
        OFF_LED:    rdata[LED_WIDTH-1:0] = led_reg;
        OFF_EDGE:   rdata[SW_WIDTH-1:0]  = edge_reg;
        OFF_IRQ_EN: rdata[SW_WIDTH-1:0]  = irq_en_reg;
        default: ;
      endcase
    end
  end

  assign bus.ReadData = rdata;

  logic unused_ok;
  assign unused_ok = ^{bus.DataAdr[1:0], bus.WriteData, BASE_ADDR[4:0], 32'(DEBOUNCE_CYCLES)};
endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: directed and random stimulus on a 10/10 and a 32/1 instance sharing one bus,
// with a scoreboard fed from a window-based behavioural model of the switch/LED register file.
module tb_gpio_mmio;
  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif
  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_IRQ = 2;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] adr       = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic [31:0] pins      = 32'h0;
  logic [9:0]  leds0;
  logic [0:0]  leds1;
  logic        irq0;
  logic        irq1;

  always #5 clk = ~clk;

  gpio_mmio_if bus0();
  gpio_mmio_if bus1();

  assign bus0.MemWrite  = mem_write;
  assign bus0.DataAdr   = adr;
  assign bus0.WriteData = wdata;
  assign bus1.MemWrite  = mem_write;
  assign bus1.DataAdr   = adr;
  assign bus1.WriteData = wdata;

  gpio_mmio #(.SW_WIDTH(10), .LED_WIDTH(10), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .switches(pins[9:0]), .leds(leds0), .irq(irq0)
  );

  gpio_mmio #(.SW_WIDTH(32), .LED_WIDTH(1), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .switches(pins), .leds(leds1), .irq(irq1)
  );

  // Model keeps 32-bit state; each instance's view is masked to its widths.
  logic [31:0] m_p1, m_s, m_deb, m_edge, m_en, m_led;
  logic [31:0] s_hist[$];

  typedef struct {
    string       name;
    int          n;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] swm(int n);
    return (n == 0) ? 32'h0000_03FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ledm(int n);
    return (n == 0) ? 32'h0000_03FF : 32'h0000_0001;
  endfunction

  function automatic logic [31:0] model_rd(int n, logic [31:0] a);
    if ((a & 32'hFFFF_FFE0) != BASE) return 32'h0;
    case (a[4:2])
      3'd0:    return m_deb & swm(n);
      3'd1:    return m_led & ledm(n);
      3'd5:    return m_edge & swm(n);
      3'd6:    return m_en & swm(n);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_s = 0; m_deb = 0; m_edge = 0; m_en = 0; m_led = 0;
    s_hist.delete();
  endtask

  // One clock edge of the model, then settle #1 past the edge.
  task automatic step();
    logic [31:0] deb_new;
    logic [31:0] clr;
    logic        all_diff;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      s_hist.push_back(m_s);
      if (s_hist.size() > D) void'(s_hist.pop_front());
`ifdef GPIO_DEBOUNCE_EN
      // A bit is accepted once the synchronised pin has disagreed with it for D consecutive edges.
      deb_new = m_deb;
      if (s_hist.size() == D) begin
        for (int i = 0; i < 32; i++) begin
          all_diff = 1'b1;
          foreach (s_hist[k]) if (s_hist[k][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) deb_new[i] = ~m_deb[i];
        end
      end
`else
      deb_new = m_p1;
`endif
      clr = 32'h0;
      if (mem_write && (adr & 32'hFFFF_FFE0) == BASE) begin
        case (adr[4:2])
          3'd1: m_led = wdata;
          3'd2: m_led = m_led | wdata;
          3'd3: m_led = m_led & ~wdata;
          3'd4: m_led = m_led ^ wdata;
          3'd5: clr = wdata;
          3'd6: m_en = wdata;
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clr) | (deb_new ^ m_deb);
      m_deb  = deb_new;
      m_s    = m_p1;
      m_p1   = pins;
    end
    #1;
  endtask

  task automatic push_exp(string name, int n, int kind, logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.n    = n;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Drive this cycle's bus inputs and queue the model's view of the current state.
  task automatic begin_cyc(logic we, logic [31:0] a, logic [31:0] d);
    mem_write = we;
    adr       = a;
    wdata     = d;
    for (int n = 0; n < 2; n++) begin
      push_exp("model_rd", n, K_RD, model_rd(n, a));
      push_exp("model_leds", n, K_LED, m_led & ledm(n));
      push_exp("model_irq", n, K_IRQ, {31'b0, |(m_edge & m_en & swm(n))});
    end
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    begin_cyc(1'b1, a, d);
    step();
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) begin
      begin_cyc(1'b0, BASE, 32'h0);
      step();
    end
  endtask

  task automatic read_const(string name, int n, logic [31:0] a, logic [31:0] exp);
    begin_cyc(1'b0, a, 32'h0);
    push_exp(name, n, K_RD, exp);
    step();
  endtask

  task automatic led_op(string name, logic [31:0] a, logic [31:0] d, logic [31:0] exp);
    wr(a, d);
    begin_cyc(1'b0, BASE + 32'h4, 32'h0);
    push_exp(name, 0, K_LED, exp);
    push_exp(name, 0, K_RD, exp);
    step();
  endtask

  function automatic logic [31:0] actual(int n, int kind);
    if (n == 0) begin
      if (kind == K_RD)  return bus0.ReadData;
      if (kind == K_LED) return {22'b0, leds0};
      return {31'b0, irq0};
    end
    if (kind == K_RD)  return bus1.ReadData;
    if (kind == K_LED) return {31'b0, leds1};
    return {31'b0, irq1};
  endfunction

  // Monitor: compare every queued expectation against the DUT away from the active edge.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = actual(e.n, e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s inst%0d kind=%0d got=%h want=%h t=%0t", e.name, e.n, e.kind, got, e.exp, $time);
        end
      end
    end
  end

  // Watchdog: the run must complete well within this bound.
  initial begin
    #1000000;
    failures++;
    $display("FAIL timeout: simulation did not complete t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] ra;
    int          off;
    #1 reset = 1'b0;
    model_reset();

    // Reset: writes and pin activity must have no effect.
    pins = 32'h3FF;
    for (int k = 0; k < 3; k++) begin
      begin_cyc(1'b1, BASE + 32'(4 * k), 32'hFFFF_FFFF);
      push_exp("rst_rd", 0, K_RD, 32'h0);
      push_exp("rst_leds", 0, K_LED, 32'h0);
      push_exp("rst_irq", 0, K_IRQ, 32'h0);
      step();
      adr = BASE;
      #0;
      checks++;
      if (leds0 !== 10'h0 || leds1 !== 1'b0 || irq0 !== 1'b0 || irq1 !== 1'b0 ||
          bus0.ReadData !== 32'h0 || bus1.ReadData !== 32'h0) begin
        failures++;
        $display("FAIL rst_state leds0=%h leds1=%h irq0=%b irq1=%b rd0=%h rd1=%h t=%0t",
                 leds0, leds1, irq0, irq1, bus0.ReadData, bus1.ReadData, $time);
      end
    end
    reset = 1'b1;

    for (int k = 0; k <= LAT + 2; k++) begin
      begin_cyc(1'b0, BASE, 32'h0);
      push_exp("sw_latency", 0, K_RD, (k >= LAT) ? 32'h3FF : 32'h0);
      step();
    end
    begin_cyc(1'b0, BASE + 32'h14, 32'h0);
    push_exp("edge_after_rst", 0, K_RD, 32'h3FF);
    push_exp("edge_after_rst", 1, K_RD, 32'h3FF);
    step();

    pins = 32'h0;
    idle(LAT + 2);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    read_const("edge_w1c", 0, BASE + 32'h14, 32'h0);

    // LED write/set/clear/toggle, then an out-of-block write.
    led_op("led_wr",  BASE + 32'h04, 32'h0F0, 32'h0F0);
    led_op("led_set", BASE + 32'h08, 32'h00F, 32'h0FF);
    led_op("led_clr", BASE + 32'h0C, 32'h030, 32'h0CF);
    led_op("led_tgl", BASE + 32'h10, 32'h301, 32'h3CE);
    led_op("led_miss", BASE + 32'h20, 32'hFFFF_FFFF, 32'h3CE);
    read_const("set_reads0", 0, BASE + 32'h08, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // A 3-cycle glitch must not reach SW or EDGE.
    pins = 32'h1;
    idle(3);
    pins = 32'h0;
    idle(LAT + 4);
    read_const("glitch_sw", 0, BASE, 32'h0);
    read_const("glitch_edge", 0, BASE + 32'h14, 32'h0);
`else
    // A 1-cycle pulse appears in SW on edge 2 and sets EDGE.
    pins = 32'h1;
    begin_cyc(1'b0, BASE, 32'h0);
    step();
    pins = 32'h0;
    begin_cyc(1'b0, BASE, 32'h0);
    step();
    read_const("pulse_sw", 0, BASE, 32'h1);
    idle(3);
    read_const("pulse_edge", 0, BASE + 32'h14, 32'h1);
`endif
    wr(BASE + 32'h14, 32'hFFFF_FFFF);

    pins = 32'h1;
    for (int k = 0; k <= LAT + 1; k++) begin
      begin_cyc(1'b0, BASE, 32'h0);
      push_exp("hold_sw", 0, K_RD, (k >= LAT) ? 32'h1 : 32'h0);
      step();
    end
    read_const("hold_edge", 0, BASE + 32'h14, 32'h1);

    // Interrupt enable, W1C drop, masked bit.
    wr(BASE + 32'h18, 32'h1);
    begin_cyc(1'b0, BASE, 32'h0);
    push_exp("irq_on", 0, K_IRQ, 32'h1);
    step();
    wr(BASE + 32'h14, 32'h1);
    begin_cyc(1'b0, BASE, 32'h0);
    push_exp("irq_off", 0, K_IRQ, 32'h0);
    step();
    pins = 32'h3;
    idle(LAT + 1);
    begin_cyc(1'b0, BASE + 32'h14, 32'h0);
    push_exp("edge1_set", 0, K_RD, 32'h2);
    push_exp("irq_masked", 0, K_IRQ, 32'h0);
    step();

    // W1C of EDGE[2] on the edge deb[2] changes: set wins.
    pins = 32'h7;
    idle(LAT - 1);
    wr(BASE + 32'h14, 32'h4);
    read_const("collide", 0, BASE + 32'h14, 32'h6);
    wr(BASE + 32'h14, 32'h4);
    read_const("w1c_after", 0, BASE + 32'h14, 32'h2);

    // Upper read bits track register width.
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    begin_cyc(1'b0, BASE + 32'h18, 32'h0);
    push_exp("en_width", 0, K_RD, 32'h3FF);
    push_exp("en_width", 1, K_RD, 32'hFFFF_FFFF);
    step();
    wr(BASE + 32'h04, 32'hFFFF_FFFF);
    begin_cyc(1'b0, BASE + 32'h04, 32'h0);
    push_exp("led_width", 0, K_RD, 32'h3FF);
    push_exp("led_width", 1, K_RD, 32'h1);
    step();

    // Random bus traffic and sparse pin flips against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) pins = pins ^ ($urandom & $urandom & $urandom);
      off = $urandom_range(0, 7);
      ra  = BASE | 32'(off << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = $urandom;
      begin_cyc($urandom_range(0, 2) == 0, ra, $urandom);
      step();
    end

    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
